// File: rtl/nrz_to_man_tx.sv
// -----------------------------------------------------------------------------
// nrz_to_man_tx
// Framed NRZ-to-Manchester transmitter. Each word accepted over tx_valid /
// tx_ready is sent as: alternating preamble (1,0,1,0,...), payload MSB first,
// then an optional even-parity bit. A 1 is sent high-then-low, a 0
// low-then-high, and each half-bit lasts one clk cycle.
//
// Ports:
//   clk        system clock, one half-bit per cycle
//   rst_n      asynchronous active-low reset
//   tx_data    word to send (captured on acceptance)
//   tx_valid   tx_data is valid
//   tx_ready   block can accept a word this cycle (combinational)
//   Man        registered Manchester serial output
//   tx_busy    a frame is on the line
//   frame_done one-cycle pulse during the final half-bit of a frame
//   half       half-bit phase of the current Man value (0 first, 1 second)
//
// state  | meaning
// -------+--------------------------------------------
// S_IDLE | no frame on the line, Man at idle level
// S_PRE  | sending preamble bits
// S_DATA | sending payload bits, MSB first
// S_PAR  | sending the even-parity bit
// -----------------------------------------------------------------------------
module nrz_to_man_tx #(
  parameter int DATA_W     = 8,
  parameter int PRE_BITS   = 4,
  parameter int PARITY_EN  = 1,
  parameter int IDLE_LEVEL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              Man,
  output logic              tx_busy,
  output logic              frame_done,
  output logic              half
);

  localparam int MAX_B = (PRE_BITS > DATA_W) ? PRE_BITS : DATA_W;
  localparam int CNT_W = $clog2(MAX_B + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
  localparam logic IDLE_MAN = 1'(IDLE_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_PAR} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;
  logic              last_bit;
  logic              accept;

  // The bit currently on the line is the last bit of the frame.
  assign last_bit = (state == S_PAR) ||
                    ((state == S_DATA) && (bit_cnt == DATA_LAST) && (PARITY_EN == 0));

  // Ready during the final half-bit lets the next frame follow with no gap.
  assign tx_ready = rst_n && ((state == S_IDLE) || (half && last_bit));
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      Man        <= IDLE_MAN;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      half       <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
    end else if (accept) begin
      // First half of bit 0 goes out on the accepting edge itself.
      shreg      <= tx_data;
      par        <= ^tx_data;
      bit_cnt    <= '0;
      half       <= 1'b0;
      tx_busy    <= 1'b1;
      frame_done <= 1'b0;
      if (PRE_BITS > 0) begin
        state <= S_PRE;
        Man   <= 1'b1;
      end else begin
        state <= S_DATA;
        Man   <= tx_data[DATA_W-1];
      end
    end else if (state != S_IDLE) begin
      if (!half) begin
        half       <= 1'b1;
        Man        <= ~Man;
        frame_done <= last_bit;
      end else begin
        // Second half done: move on to the first half of the next bit.
        half       <= 1'b0;
        frame_done <= 1'b0;
        case (state)
          S_PRE: begin
            if (bit_cnt == PRE_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
              Man     <= shreg[DATA_W-1];
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // Preamble index i carries ~i[0]; next index is bit_cnt+1.
              Man     <= bit_cnt[0];
            end
          end
          S_DATA: begin
            if (bit_cnt == DATA_LAST) begin
              if (PARITY_EN != 0) begin
                state <= S_PAR;
                Man   <= par;
              end else begin
                state   <= S_IDLE;
                Man     <= IDLE_MAN;
                tx_busy <= 1'b0;
                bit_cnt <= '0;
              end
            end else begin
              shreg   <= shreg << 1;
              bit_cnt <= bit_cnt + 1'b1;
              Man     <= shreg[DATA_W-2];
            end
          end
          default: begin
            state   <= S_IDLE;
            Man     <= IDLE_MAN;
            tx_busy <= 1'b0;
            bit_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrz_to_man_tx.sv
// -----------------------------------------------------------------------------
// tb_nrz_to_man_tx
// Drives two transmitters (parity on / parity off) from shared inputs and
// compares every cycle against a frame-level model: each accepted word becomes
// a precomputed string of half-bits that is consumed one per clock. Fixed
// vectors cover known frames; a random stream is decoded back from Man.
// -----------------------------------------------------------------------------
module tb_nrz_to_man_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  logic man0, busy0, done0, half0, ready0;
  logic man1, busy1, done1, half1, ready1;

  nrz_to_man_tx #(.DATA_W(8), .PRE_BITS(4), .PARITY_EN(1), .IDLE_LEVEL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready0), .Man(man0), .tx_busy(busy0), .frame_done(done0), .half(half0)
  );

  nrz_to_man_tx #(.DATA_W(8), .PRE_BITS(4), .PARITY_EN(0), .IDLE_LEVEL(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(ready1), .Man(man1), .tx_busy(busy1), .frame_done(done1), .half(half1)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: remaining half-bits of the current frame, first half at rem-1.
  logic [63:0] seq [2];
  int          rem [2];
  logic        last_acc0;

  logic [63:0] lg0, lg1;

  // Round-trip decoder state
  logic        dec_en;
  int          dec_cnt;
  logic [63:0] dec_buf;
  logic [7:0]  sent [$];

  typedef struct {
    logic [7:0]  data;
    logic [25:0] exp0;
    logic [23:0] exp1;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int frame_len(input int m);
    return 2 * (4 + 8 + ((m == 0) ? 1 : 0));
  endfunction

  function automatic logic [63:0] build(input int m, input logic [7:0] d);
    logic [63:0] s;
    logic        b;
    int          ones;
    s = '0;
    ones = 0;
    for (int i = 0; i < 4; i++) begin
      b = (i % 2 == 0);
      s = {s[61:0], b, ~b};
    end
    for (int i = 7; i >= 0; i--) begin
      b = d[i];
      if (b) ones++;
      s = {s[61:0], b, ~b};
    end
    if (m == 0) begin
      b = (ones % 2 == 1);
      s = {s[61:0], b, ~b};
    end
    return s;
  endfunction

  function automatic logic [4:0] model_outs(input int m);
    logic mv;
    mv = (rem[m] > 0) ? seq[m][rem[m]-1] : 1'b0;
    return {mv, rem[m] > 0, rem[m] == 1, rem[m] % 2 == 1, rst_n && (rem[m] <= 1)};
  endfunction

  task automatic decode_sample();
    logic [7:0] word;
    logic       ok;
    logic [1:0] pair;
    if (dec_cnt > 0 || man0 != 1'b0) begin
      dec_buf = {dec_buf[62:0], man0};
      dec_cnt++;
      if (dec_cnt == 26) begin
        ok = 1'b1;
        word = '0;
        for (int i = 0; i < 13; i++) begin
          pair = dec_buf[25-2*i -: 2];
          if (pair[1] == pair[0]) ok = 1'b0;
          if (i >= 4 && i < 12) word = {word[6:0], pair[1]};
        end
        if (sent.size() == 0) check("roundtrip_extra_frame", {ok, word}, 64'h0);
        else check("roundtrip_word", {ok, word}, {1'b1, sent.pop_front()});
        dec_cnt = 0;
      end
    end
  endtask

  task automatic check_outputs();
    check("dut0_outputs", {man0, busy0, done0, half0, ready0}, model_outs(0));
    check("dut1_outputs", {man1, busy1, done1, half1, ready1}, model_outs(1));
    lg0 = {lg0[62:0], man0};
    lg1 = {lg1[62:0], man1};
    if (dec_en) decode_sample();
  endtask

  // Called just after a negedge: drive, clock, update model, sample.
  task automatic step(input logic v, input logic [7:0] d);
    logic a [2];
    tx_valid = v;
    tx_data  = d;
    for (int m = 0; m < 2; m++) a[m] = v && rst_n && (rem[m] <= 1);
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (a[m]) begin
        seq[m] = build(m, d);
        rem[m] = frame_len(m);
      end else if (rem[m] > 0) begin
        rem[m]--;
      end
    end
    @(negedge clk);
    check_outputs();
    last_acc0 = a[0];
  endtask

  initial begin
    int idx;
    int n_sent;
    rem[0] = 0; rem[1] = 0;
    seq[0] = '0; seq[1] = '0;
    lg0 = '0; lg1 = '0;
    dec_en = 1'b0; dec_cnt = 0; dec_buf = '0;
    last_acc0 = 1'b0;

    tbl[0] = '{8'hA5, 26'b10011001_1001100101100110_01, 24'b10011001_1001100101100110};
    tbl[1] = '{8'h01, 26'b10011001_0101010101010110_10, 24'b10011001_0101010101010110};
    tbl[2] = '{8'hFF, 26'b10011001_1010101010101010_01, 24'b10011001_1010101010101010};
    tbl[3] = '{8'h00, 26'b10011001_0101010101010101_01, 24'b10011001_0101010101010101};
    tbl[4] = '{8'h3C, 26'b10011001_0101101010100101_01, 24'b10011001_0101101010100101};

    // Reset with no clock edge yet
    #2;
    check("reset_dut0", {man0, busy0, done0, half0, ready0}, 5'b00000);
    check("reset_dut1", {man1, busy1, done1, half1, ready1}, 5'b00000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready0", {man0, busy0, done0, half0, ready0}, 5'b00001);
    check("post_reset_ready1", {man1, busy1, done1, half1, ready1}, 5'b00001);
    @(negedge clk);

    // Single frames from the vector table; data changes after acceptance
    for (int t = 0; t < 5; t++) begin
      step(1'b1, tbl[t].data);
      repeat (25) step(1'b0, 8'($urandom));
      check($sformatf("frame_par_%02h", tbl[t].data), lg0[25:0], tbl[t].exp0);
      check($sformatf("frame_nopar_%02h", tbl[t].data), lg1[25:0], {tbl[t].exp1, 2'b00});
      step(1'b0, 8'h00);
    end

    // Back-to-back with tx_valid held: 0xFF then 0x00, no idle gap
    step(1'b1, 8'hFF);
    repeat (26) step(1'b1, 8'h00);
    check("b2b_second_accept", last_acc0, 1'b1);
    repeat (25) step(1'b0, 8'h00);
    check("b2b_stream", lg0[51:0], {tbl[2].exp0, tbl[3].exp0});
    repeat (30) step(1'b0, 8'h00);

    // Stall: 0x3C offered from cycle 11 is held off until the final half-bit
    step(1'b1, 8'hA5);
    idx = 1;
    repeat (9) begin step(1'b0, 8'($urandom)); idx++; end
    last_acc0 = 1'b0;
    while (!last_acc0 && idx < 40) begin
      idx++;
      step(1'b1, 8'h3C);
    end
    check("stall_accept_cycle", idx, 27);
    repeat (25) step(1'b0, 8'($urandom));
    check("stall_frame_3c", lg0[25:0], tbl[4].exp0);
    repeat (30) step(1'b0, 8'h00);

    // Reset mid-frame aborts immediately
    step(1'b1, 8'hA5);
    repeat (5) step(1'b0, 8'h00);
    #1 rst_n = 1'b0;
    #1;
    check("abort_dut0", {man0, busy0, done0, half0, ready0}, 5'b00000);
    check("abort_dut1", {man1, busy1, done1, half1, ready1}, 5'b00000);
    rem[0] = 0; rem[1] = 0;
    #1 rst_n = 1'b1;
    #1;
    check("abort_release0", {man0, busy0, done0, half0, ready0}, 5'b00001);
    @(negedge clk);
    check_outputs();
    repeat (5) step(1'b0, 8'h00);

    // Random stream decoded back from the line
    dec_en = 1'b1;
    dec_cnt = 0;
    n_sent = 0;
    for (int k = 0; k < 20000 && n_sent < 200; k++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom));
      if (last_acc0) begin
        sent.push_back(tx_data);
        n_sent++;
      end
    end
    check("random_words_sent", n_sent, 200);
    repeat (30) step(1'b0, 8'h00);
    check("roundtrip_all_decoded", sent.size(), 0);
    dec_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
